// File: rtl/codec_intf_if.sv
// ---------------------------------------------------------------------------
// codec_intf_if
//   Bundles the signals between the codec interface block, the equalizer core
//   and the external stereo codec.
//
//   Core side : tx_lft, tx_rht (core -> block), rx_lft, rx_rht, valid
//               (block -> core)
//   Codec side: SDin (codec -> block), SDout, MCLK, SCLK, LRCLK, RSTn
//               (block -> codec)
//
//   slave  : view taken by codec_intf itself
//   master : view taken by whatever surrounds it (core + codec, or a bench)
// ---------------------------------------------------------------------------
interface codec_intf_if;
  logic [15:0] tx_lft;
  logic [15:0] tx_rht;
  logic [15:0] rx_lft;
  logic [15:0] rx_rht;
  logic        valid;
  logic        SDin;
  logic        SDout;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        RSTn;

  modport slave (
    input  tx_lft, tx_rht, SDin,
    output rx_lft, rx_rht, valid, SDout, MCLK, SCLK, LRCLK, RSTn
  );

  modport master (
    output tx_lft, tx_rht, SDin,
    input  rx_lft, rx_rht, valid, SDout, MCLK, SCLK, LRCLK, RSTn
  );
endinterface

// File: rtl/codec_intf.sv
// ---------------------------------------------------------------------------
// codec_intf
//   I2S bridge between a stereo audio codec and the equalizer core.
//   A free-running 10-bit counter defines one stereo frame of 1024 clk.
//   From it the block derives the codec clocks (MCLK = clk/4, SCLK = clk/32,
//   LRCLK = clk/1024) and the codec reset, deserializes ADC data from SDin
//   into 16-bit left/right words with a one-clk valid strobe, and serializes
//   the core's left/right words onto SDout.
//
//   Frame layout (slot k = cnt[9:5], one SCLK period each):
//     slot 1..16  : left  bit 15..0  (one-bit I2S delay after LRCLK fall)
//     slot 17..31 : right bit 15..1
//     slot 0      : right bit 0 of the previous frame
//
// Ports:
//   clk    system clock (50 MHz)
//   rst_n  asynchronous active-low reset
//   bus    codec_intf_if.slave : tx_lft/tx_rht in, rx_lft/rx_rht/valid out,
//          SDin in, SDout/MCLK/SCLK/LRCLK/RSTn out
// ---------------------------------------------------------------------------
module codec_intf (
  input  logic        clk,
  input  logic        rst_n,
  codec_intf_if.slave bus
);

  // Frame timing
  logic [9:0]  cnt_r;
  logic [9:0]  cnt_nxt_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        tx_load_s;
  logic        rx_cap_s;
  logic        wrap_s;

  // Codec wake-up tracking: counts frame wraps, saturating at 2
  logic [1:0]  wrp_r;
  logic [1:0]  wrp_nxt_s;

  // Registered codec clocks and reset
  logic        mclk_r;
  logic        sclk_r;
  logic        lrclk_r;
  logic        rstn_r;

  // Receive path
  logic [31:0] rx_shft_r;
  logic [15:0] rx_lft_r;
  logic [15:0] rx_rht_r;
  logic        valid_r;

  // Transmit path
  logic [31:0] tx_shft_r;
  logic [31:0] tx_nxt_s;
  logic        sdout_r;

  // Counter advance and decode of the per-frame event points.
  // Events are decoded from the counter value *before* the edge, so the
  // SCLK rise (cnt[4:0]==15) and the receive shift happen on the same edge.
  always_comb begin
    cnt_nxt_s   = cnt_r + 10'd1;
    sclk_rise_s = (cnt_r[4:0] == 5'd15);
    sclk_fall_s = (cnt_r[4:0] == 5'd31);
    tx_load_s   = (cnt_r == 10'd31);
    rx_cap_s    = (cnt_r == 10'd16);
    wrap_s      = (cnt_r == 10'd1023);
  end

  // Saturating wrap counter update: 0 -> 1 -> 2, then hold.
  always_comb begin
    wrp_nxt_s = wrp_r;
    case (wrp_r)
      2'd0: begin
        if (wrap_s) begin
          wrp_nxt_s = 2'd1;
        end else begin
          wrp_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (wrap_s) begin
          wrp_nxt_s = 2'd2;
        end else begin
          wrp_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        wrp_nxt_s = 2'd2;
      end
      default: begin
        // Unreachable encoding; steer back to the saturated state.
        wrp_nxt_s = 2'd2;
      end
    endcase
  end

  // Transmit shifter next value: load a fresh stereo word at the slot-0
  // SCLK fall, otherwise shift left on every SCLK fall.
  always_comb begin
    tx_nxt_s = tx_shft_r;
    if (sclk_fall_s) begin
      if (tx_load_s) begin
        tx_nxt_s = {bus.tx_lft, bus.tx_rht};
      end else begin
        tx_nxt_s = {tx_shft_r[30:0], 1'b0};
      end
    end else begin
      tx_nxt_s = tx_shft_r;
    end
  end

  // Free-running frame counter, wraps 1023 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrp_r <= 2'd0;
    end else begin
      wrp_r <= wrp_nxt_s;
    end
  end

  // Codec clocks are registered copies of the next counter value, so each
  // output is glitch-free and lines up exactly with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_r  <= 1'b0;
      sclk_r  <= 1'b0;
      lrclk_r <= 1'b0;
    end else begin
      mclk_r  <= cnt_nxt_s[1];
      sclk_r  <= cnt_nxt_s[4];
      lrclk_r <= cnt_nxt_s[9];
    end
  end

  // Codec reset releases on the edge of the first frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstn_r <= 1'b0;
    end else begin
      rstn_r <= (wrp_nxt_s != 2'd0);
    end
  end

  // Receive shifter: sample SDin on every SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft_r <= 32'd0;
    end else if (sclk_rise_s) begin
      rx_shft_r <= {rx_shft_r[30:0], bus.SDin};
    end else begin
      rx_shft_r <= rx_shft_r;
    end
  end

  // Parallel capture one clk after the slot-0 rise, when the shifter holds
  // a complete left/right pair. Data is only flagged valid once the codec
  // has been out of reset for a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_lft_r <= 16'd0;
      rx_rht_r <= 16'd0;
      valid_r  <= 1'b0;
    end else if (rx_cap_s) begin
      rx_lft_r <= rx_shft_r[31:16];
      rx_rht_r <= rx_shft_r[15:0];
      valid_r  <= (wrp_r == 2'd2);
    end else begin
      rx_lft_r <= rx_lft_r;
      rx_rht_r <= rx_rht_r;
      valid_r  <= 1'b0;
    end
  end

  // Transmit shifter and serial output; SDout only moves on SCLK fall so
  // the codec sees stable data at every SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft_r <= 32'd0;
      sdout_r   <= 1'b0;
    end else if (sclk_fall_s) begin
      tx_shft_r <= tx_nxt_s;
      sdout_r   <= tx_nxt_s[31];
    end else begin
      tx_shft_r <= tx_shft_r;
      sdout_r   <= sdout_r;
    end
  end

  assign bus.MCLK   = mclk_r;
  assign bus.SCLK   = sclk_r;
  assign bus.LRCLK  = lrclk_r;
  assign bus.RSTn   = rstn_r;
  assign bus.rx_lft = rx_lft_r;
  assign bus.rx_rht = rx_rht_r;
  assign bus.valid  = valid_r;
  assign bus.SDout  = sdout_r;

endmodule

// File: tb/tb_codec_intf.sv
// ---------------------------------------------------------------------------
// tb_codec_intf
//   Self-checking bench for codec_intf. The reference is a frame-level view
//   of the I2S link: the bench counts clk edges since reset release (n) and
//   derives every expected output from n, from per-frame tables of the words
//   the codec sends (or loopback) and the words the core offers for transmit.
// ---------------------------------------------------------------------------
module tb_codec_intf;

  logic clk;
  logic rst_n;

  codec_intf_if bus ();

  codec_intf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SDin comes from the codec model or, in loopback frames, from SDout.
  logic loop_sel;
  logic codec_bit;
  assign bus.SDin = loop_sel ? bus.SDout : codec_bit;

  // Per-frame tables for the current reset session
  localparam int NFR = 16;
  logic [15:0] tx_pl_l [NFR];   // word offered by the core during frame f
  logic [15:0] tx_pl_r [NFR];
  logic [15:0] cd_l    [NFR];   // word the codec sends in frame f
  logic [15:0] cd_r    [NFR];
  logic        lp      [NFR];   // frame f received over loopback
  logic [15:0] ex_l    [NFR];   // word expected at rx for frame f
  logic [15:0] ex_r    [NFR];

  int          vectors;
  int          errors;
  int          n;
  logic        sdout_prev;
  logic [31:0] wbuf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h (n=%0d)", tag, obs, exp_v, n);
    end
  endtask

  task automatic build_plan();
    for (int f = 0; f < NFR; f++) begin
      tx_pl_l[f] = 16'($urandom);
      tx_pl_r[f] = 16'($urandom);
      cd_l[f]    = 16'($urandom);
      cd_r[f]    = 16'($urandom);
      lp[f]      = 1'b0;
      if (f < 4) begin
        tx_pl_l[f] = 16'h8001;
        tx_pl_r[f] = 16'h7FFE;
        cd_l[f]    = 16'hA5C3;
        cd_r[f]    = 16'h3C5A;
      end
      if (f == 4) tx_pl_l[f] = 16'h0000;
      if (f == 5) tx_pl_l[f] = 16'hFFFF;
      if (f == 8 || f == 9) begin
        tx_pl_l[f] = 16'h1234;
        tx_pl_r[f] = 16'hFEDC;
        lp[f]      = 1'b1;
      end
      ex_l[f] = lp[f] ? tx_pl_l[f] : cd_l[f];
      ex_r[f] = lp[f] ? tx_pl_r[f] : cd_r[f];
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_mclk"},  {31'd0, bus.MCLK},  32'd0);
    chk({pfx, "_sclk"},  {31'd0, bus.SCLK},  32'd0);
    chk({pfx, "_lrclk"}, {31'd0, bus.LRCLK}, 32'd0);
    chk({pfx, "_rstn"},  {31'd0, bus.RSTn},  32'd0);
    chk({pfx, "_valid"}, {31'd0, bus.valid}, 32'd0);
    chk({pfx, "_sdout"}, {31'd0, bus.SDout}, 32'd0);
    chk({pfx, "_rxl"},   {16'd0, bus.rx_lft}, 32'd0);
    chk({pfx, "_rxr"},   {16'd0, bus.rx_rht}, 32'd0);
  endtask

  // Check the state after n edges and set up inputs for edge n+1.
  task automatic step();
    int cyc;
    int slot;
    int fr;
    int bf;
    int cf;
    logic exp_valid;
    cyc  = n % 1024;
    slot = cyc / 32;
    fr   = n / 1024;

    chk("mclk",  {31'd0, bus.MCLK},  32'((n / 2) % 2));
    chk("sclk",  {31'd0, bus.SCLK},  32'((n / 16) % 2));
    chk("lrclk", {31'd0, bus.LRCLK}, 32'((n / 512) % 2));
    chk("rstn",  {31'd0, bus.RSTn},  32'(n >= 1024));
    exp_valid = (cyc == 17) && (n >= 2048 + 17);
    chk("valid", {31'd0, bus.valid}, {31'd0, exp_valid});

    // Received words: fresh at each valid, held in between.
    if (n >= 2048 + 17 && (exp_valid || (n % 32) == 0)) begin
      cf = (n - 17) / 1024 - 1;
      chk("rx_lft", {16'd0, bus.rx_lft}, {16'd0, ex_l[cf]});
      chk("rx_rht", {16'd0, bus.rx_rht}, {16'd0, ex_r[cf]});
    end

    // SDout may only change right after an SCLK fall.
    if (n > 0 && (n % 32) != 0) begin
      chk("sdout_stable", {31'd0, bus.SDout}, {31'd0, sdout_prev});
    end
    sdout_prev = bus.SDout;

    // Deserialize SDout as the codec would, on SCLK rise.
    if ((n % 32) == 15) begin
      wbuf = {wbuf[30:0], bus.SDout};
      if (slot == 0 && n >= 1024) begin
        chk("tx_word", wbuf, {tx_pl_l[fr - 1], tx_pl_r[fr - 1]});
      end
    end

    // Codec model: bit for the slot being sampled at the next rise.
    bf = (slot == 0) ? fr - 1 : fr;
    if (bf < 0) begin
      loop_sel  = 1'b0;
      codec_bit = 1'b0;
    end else begin
      loop_sel = lp[bf];
      if (slot == 0)       codec_bit = cd_r[bf][0];
      else if (slot <= 16) codec_bit = cd_l[bf][16 - slot];
      else                 codec_bit = cd_r[bf][32 - slot];
    end

    // Core updates its output well after the load point of this frame.
    if (cyc == 200) begin
      bus.tx_lft = tx_pl_l[fr + 1];
      bus.tx_rht = tx_pl_r[fr + 1];
    end
  endtask

  task automatic run_session(input int ncyc);
    n          = 0;
    sdout_prev = 1'b0;
    wbuf       = 32'd0;
    rst_n      = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (i != 0) @(negedge clk);
      step();
      n++;
    end
  endtask

  task automatic prep_session();
    build_plan();
    bus.tx_lft = tx_pl_l[0];
    bus.tx_rht = tx_pl_r[0];
    loop_sel   = 1'b0;
    codec_bit  = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    n       = 0;
    rst_n   = 1'b0;
    prep_session();
    repeat (3) @(negedge clk);
    check_all_zero("por");

    // Session 1: twelve full frames, then reset mid-frame at cnt==600.
    run_session(12 * 1024 + 601);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");

    prep_session();
    repeat (2) @(negedge clk);
    check_all_zero("inrst");

    // Session 2: codec reset and valid must restart from scratch.
    run_session(3 * 1024 + 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Bidirectional serial interface between the stereo audio codec and the equalizer core.
- Generates the codec clocks (MCLK, SCLK, LRCLK) and the codec reset from the system clock.
- Deserializes codec ADC data on SDin into parallel left/right samples with a `valid` strobe for the core.
- Serializes the core's processed left/right samples onto SDout, I2S format, 16-bit per channel.

Parameters:
none (timing fixed: 10-bit frame counter, 1024 clk per stereo frame)

Ports:
clk      input   1   system clock (50 MHz)
rst_n    input   1   asynchronous active-low reset
tx_lft   input   16  left sample from core to transmit (core lft_out)
tx_rht   input   16  right sample from core to transmit (core rht_out)
SDin     input   1   serial ADC data from codec
rx_lft   output  16  received left sample (to core lft_in)
rx_rht   output  16  received right sample (to core rht_in)
valid    output  1   one-clk pulse: rx_lft/rx_rht updated this cycle
SDout    output  1   serial DAC data to codec
MCLK     output  1   codec master clock, clk/4
SCLK     output  1   serial bit clock, clk/32
LRCLK    output  1   word select, clk/1024; 0 = left, 1 = right
RSTn     output  1   codec reset, active low

Behaviour:
- Reset is asynchronous, active-low, on clk/rst_n. Assertion at any time, including mid-frame, returns every register to its reset value immediately.
- Reset values: all outputs 0 (RSTn=0, valid=0, SDout=0, rx_lft=rx_rht=0, clocks 0); cnt=0; rx_shft=tx_shft=0; wrap counter=0.
- cnt[9:0] is free running and increments every clk, wrapping 1023->0.
- Clock outputs are registered copies of the next counter value:
  - MCLK = cnt[1]
  - SCLK = cnt[4]
  - LRCLK = cnt[9]
  - Edges align with the counter, no glitches.
- SCLK rise edge: the clk edge at which cnt[4:0]==15. SCLK fall edge: the clk edge at which cnt[4:0]==31.
- Frame slot k = cnt[9:5], range 0..31.
- Wrap counter wrp (2-bit, saturating at 2) increments on each edge with cnt==1023.
  - RSTn = (wrp!=0), registered. RSTn goes high at the edge where cnt wraps the first time.
  - Receive data is qualified only when wrp==2.
- Receive:
  - On every SCLK rise edge: rx_shft[31:0] <= {rx_shft[30:0], SDin}.
  - I2S one-bit delay applies: left MSB is sampled at slot-1 rise, left LSB at slot-16 rise, right MSB at slot-17 rise, right LSB at slot-0 rise of the next frame.
  - On the edge with cnt==16:
    - rx_lft <= rx_shft[31:16]
    - rx_rht <= rx_shft[15:0]
    - valid <= (wrp==2)
  - valid is 1 for exactly one clk; 0 on all other edges. rx_* hold between updates.
- Transmit:
  - On the SCLK fall edge with slot 0 (cnt==31): tx_shft <= {tx_lft, tx_rht}, and SDout takes the new tx_shft[31] (= tx_lft[15]).
  - On all other SCLK fall edges: tx_shft <= {tx_shft[30:0], 1'b0}, and SDout takes the new MSB.
  - SDout changes only on SCLK fall, so the codec samples it on SCLK rise.
  - Result: left[15] is sampled at slot-1 rise, left[0] at slot-16 rise (first rise with LRCLK=1), right[0] at slot-0 rise of the next frame.
- tx_lft/tx_rht are sampled only at cnt==31. Changes at other times do not affect the frame in flight.
- Simultaneous events: at cnt==15 the shift into rx_shft and the rise of SCLK occur on the same edge. The capture at cnt==16 sees the shifted value.
- No back-pressure: the core must consume each sample within one frame (1024 clk).

Test Plan:
- Reset release, idle SDin=0 -> SCLK period 32 clk, LRCLK period 1024 clk, MCLK period 4 clk. RSTn rises at clk 1024. No valid before clk ~2064. First valid at cnt==16 of the third frame.
- Codec model drives left=16'hA5C3, right=16'h3C5A in I2S format on SDin -> each valid pulse has rx_lft==16'hA5C3, rx_rht==16'h3C5A. valid pulse width exactly 1 clk, spacing exactly 1024 clk.
- tx_lft=16'h8001, tx_rht=16'h7FFE held constant -> bench deserializes SDout on SCLK rise and recovers 8001/7FFE every frame. SDout never toggles except on SCLK fall.
- Loopback SDout->SDin with tx_lft=16'h1234, tx_rht=16'hFEDC -> rx_lft/rx_rht equal 1234/FEDC, one frame later.
- Change tx_lft from 16'h0000 to 16'hFFFF at cnt==200 -> the current frame still transmits 0000; the next frame transmits FFFF.
- Assert rst_n low at cnt==600 mid-frame -> all outputs 0 asynchronously, same cycle. After release, RSTn re-rises after 1024 clk and valid resumes only after the second wrap.
